// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache:
// controller state encoding, line/word geometry and field-width helpers.
package dcache_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    // Fixed line geometry: 8 x 32-bit words per 256-bit line
    localparam int ADDR_W         = 32;
    localparam int LINE_BITS      = 256;
    localparam int WORD_BITS      = 32;
    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_SEL_W     = 3;
    localparam int OFFSET_W       = 5;

    // Default number of cache lines
    localparam int DEFAULT_LINES  = 32;

    // Index field width for a cache of the given number of lines
    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Tag field width: everything above index and byte offset
    function automatic int tag_width(input int lines);
        return ADDR_W - OFFSET_W - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid, dirty and data storage for the direct-mapped cache.
// One combinational read port, one synchronous write port (word or full
// line), and an asynchronous clear of valid/dirty. Tags and data are not
// cleared; a cleared valid bit makes their contents irrelevant.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES,
    parameter int IDX_W = idx_width(LINES),
    parameter int TAG_W = tag_width(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // read port
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    // write port
    input  logic                  wr_word_en,
    input  logic                  wr_line_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WORD_SEL_W-1:0] wr_word_sel,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [LINE_BITS-1:0]  wr_line
);

    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [LINE_BITS-1:0] data_mem [LINES];
    logic [LINES-1:0]     valid_vec;
    logic [LINES-1:0]     dirty_vec;

    // Per-line status flags. A line fill makes the line valid and clean;
    // a word write only marks it dirty.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_flags
        logic valid_reg;
        logic dirty_reg;

        // Update this line's flags when the write port targets it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                dirty_reg <= 1'b0;
            end else if (wr_idx == IDX_W'(gi)) begin
                if (wr_line_en) begin
                    valid_reg <= 1'b1;
                    dirty_reg <= 1'b0;
                end else if (wr_word_en) begin
                    dirty_reg <= 1'b1;
                end
            end
        end

        assign valid_vec[gi] = valid_reg;
        assign dirty_vec[gi] = dirty_reg;
    end

    // Tag and data storage; a line fill takes priority over a word write
    always_ff @(posedge clk) begin
        if (wr_line_en) begin
            data_mem[wr_idx] <= wr_line;
            tag_mem[wr_idx]  <= wr_tag;
        end else if (wr_word_en) begin
            data_mem[wr_idx][wr_word_sel*WORD_BITS +: WORD_BITS] <= wr_word;
        end
    end

    assign rd_valid = valid_vec[rd_idx];
    assign rd_dirty = dirty_vec[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are served combinationally in the MEM stage. A miss stalls the
// pipeline, writes back a dirty victim, refills the line and then lets the
// held access re-evaluate as a hit.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = DEFAULT_LINES
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    output logic [31:0]          cpu_rdata_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_wdata_o,
    input  logic [LINE_BITS-1:0] mem_rdata_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(LINES);

    state_t state_reg;

    // Address fields; the byte-within-word bits never matter
    logic [WORD_SEL_W-1:0] word_sel;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  unused_byte_bits;

    assign word_sel         = cpu_addr_i[OFFSET_W-1:2];
    assign idx              = cpu_addr_i[OFFSET_W +: IDX_W];
    assign tag              = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign unused_byte_bits = ^cpu_addr_i[1:0];

    // Storage read-out for the addressed line
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [LINE_BITS-1:0] line_data;

    logic hit;
    logic miss;
    logic store_hit;
    logic refill_done;

    assign hit         = line_valid & (line_tag == tag);
    assign miss        = cpu_req_i & ~hit;
    assign store_hit   = (state_reg == IDLE) & cpu_req_i & cpu_we_i & hit;
    assign refill_done = (state_reg == ALLOCATE) & mem_ack_i;

    dcache_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk         (clk_i),
        .rst_n       (rst_i),
        .rd_idx      (idx),
        .rd_valid    (line_valid),
        .rd_dirty    (line_dirty),
        .rd_tag      (line_tag),
        .rd_line     (line_data),
        .wr_word_en  (store_hit),
        .wr_line_en  (refill_done),
        .wr_idx      (idx),
        .wr_word_sel (word_sel),
        .wr_word     (cpu_wdata_i),
        .wr_tag      (tag),
        .wr_line     (mem_rdata_i)
    );

    // Split the line into words for the load mux
    logic [WORD_BITS-1:0] line_words [WORDS_PER_LINE];

    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_words
        assign line_words[gi] = line_data[gi*WORD_BITS +: WORD_BITS];
    end

    // Load data is only driven on a hit so stale or unreset storage never leaks out
    assign cpu_rdata_o = hit ? line_words[word_sel] : '0;

    // Stall while a miss is outstanding, and in the detect cycle itself
    assign cpu_stall_o = (state_reg != IDLE) | miss;

    // Miss-handling FSM with registered memory-side outputs. The CPU holds
    // its request stable during the stall, so idx/tag stay valid throughout.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg   <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss) begin
                        mem_req_o <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state_reg   <= WRITEBACK;
                            mem_we_o    <= 1'b1;
                            mem_addr_o  <= {line_tag, idx, {OFFSET_W{1'b0}}};
                            mem_wdata_o <= line_data;
                        end else begin
                            state_reg  <= ALLOCATE;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= {tag, idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    // Victim accepted: keep the request up and switch to the fetch
                    if (mem_ack_i) begin
                        state_reg  <= ALLOCATE;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= {tag, idx, {OFFSET_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    // Line is written into the array on this same ack
                    if (mem_ack_i) begin
                        state_reg  <= IDLE;
                        mem_req_o  <= 1'b0;
                        mem_we_o   <= 1'b0;
                        mem_addr_o <= '0;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    mem_req_o  <= 1'b0;
                    mem_we_o   <= 1'b0;
                    mem_addr_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus randomized
// accesses, checked every cycle against a line-level cache/memory model.
module tb_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    always #5 clk = ~clk;

    dcache_ctrl #(.LINES(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int txn_no   = 0;
    int lat_fixed = 3;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    endtask

    // ---------------- behavioural memory and cache model ----------------
    logic [255:0] mem_arr [int unsigned];

    function automatic logic [255:0] mem_line(input int unsigned la);
        logic [255:0] l;
        if (mem_arr.exists(la)) return mem_arr[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = 32'h5A00_0000 ^ (la << 8) ^ w;
        return l;
    endfunction

    bit           m_valid [32];
    bit           m_dirty [32];
    int unsigned  m_tag   [32];
    logic [31:0]  m_data  [32][8];

    function automatic logic [255:0] model_line(input int unsigned i);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = m_data[i][w];
        return l;
    endfunction

    typedef struct {
        bit           wb;
        logic [31:0]  addr;
        logic [255:0] data;
    } txn_t;

    txn_t exp_q[$];

    int unsigned  c_idx, c_tag, c_w, f_idx;
    bit           c_hit;
    txn_t         c_t;
    logic [255:0] c_line;

    // Per-cycle compare: outputs versus the model, then advance the model
    // to the state it will have after the coming rising edge.
    always @(negedge clk) begin
        if (!rst_i) begin
            chk("rst_mem_req", mem_req_o, 0);
            chk("rst_mem_we", mem_we_o, 0);
            chk("rst_mem_addr", mem_addr_o, 0);
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 1'b0;
                m_dirty[i] = 1'b0;
            end
            exp_q.delete();
        end else begin
            c_idx = (cpu_addr_i >> 5) % 32;
            c_tag = cpu_addr_i >> 10;
            c_w   = (cpu_addr_i >> 2) % 8;
            c_hit = m_valid[c_idx] && (m_tag[c_idx] == c_tag);
            chk("rdata", cpu_rdata_o, c_hit ? m_data[c_idx][c_w] : 32'h0);
            if (exp_q.size() == 0) begin
                chk("mem_req_idle", mem_req_o, 0);
                chk("stall", cpu_stall_o, cpu_req_i && !c_hit);
                if (cpu_req_i && c_hit && cpu_we_i) begin
                    m_data[c_idx][c_w] = cpu_wdata_i;
                    m_dirty[c_idx]     = 1'b1;
                end else if (cpu_req_i && !c_hit) begin
                    if (m_valid[c_idx] && m_dirty[c_idx])
                        exp_q.push_back('{1'b1, (m_tag[c_idx] << 10) | (c_idx << 5), model_line(c_idx)});
                    exp_q.push_back('{1'b0, cpu_addr_i & ~32'h1F, 256'h0});
                end
            end else begin
                c_t = exp_q[0];
                chk("stall_busy", cpu_stall_o, 1);
                chk("mem_req", mem_req_o, 1);
                chk("mem_we", mem_we_o, c_t.wb);
                chk("mem_addr", mem_addr_o, c_t.addr);
                if (c_t.wb) chk("mem_wdata", mem_wdata_o, c_t.data);
                if (mem_ack_i) begin
                    void'(exp_q.pop_front());
                    if (c_t.wb) begin
                        mem_arr[c_t.addr >> 5] = c_t.data;
                    end else begin
                        f_idx  = (c_t.addr >> 5) % 32;
                        c_line = mem_line(c_t.addr >> 5);
                        for (int w = 0; w < 8; w++) m_data[f_idx][w] = c_line[w*32 +: 32];
                        m_valid[f_idx] = 1'b1;
                        m_dirty[f_idx] = 1'b0;
                        m_tag[f_idx]   = c_t.addr >> 10;
                    end
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    int  resp_cnt;
    bit  resp_busy;

    function automatic int pick_lat();
        return (lat_fixed < 0) ? int'($urandom_range(0, 4)) : lat_fixed;
    endfunction

    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        resp_busy   = 1'b0;
        resp_cnt    = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_i) begin
                mem_ack_i = 1'b0;
                resp_busy = 1'b0;
            end else if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                if (mem_req_o) begin
                    resp_busy = 1'b1;
                    resp_cnt  = pick_lat();
                end else begin
                    resp_busy = 1'b0;
                end
            end else if (resp_busy) begin
                if (resp_cnt == 0) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = mem_we_o ? {8{$urandom}} : mem_line(mem_addr_o >> 5);
                end else begin
                    resp_cnt--;
                end
            end else if (mem_req_o) begin
                resp_busy = 1'b1;
                resp_cnt  = pick_lat();
            end
        end
    end

    // ---------------- CPU driver ----------------
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output bit saw_wb, output logic [31:0] first_addr,
                          output bit first_we, output logic [31:0] last_addr,
                          output logic [31:0] wb_w1, output logic [31:0] rdata);
        bit done = 1'b0;
        bit got  = 1'b0;
        stalls = 0; saw_wb = 0; first_addr = 0; first_we = 0;
        last_addr = 0; wb_w1 = 0; rdata = 0;
        @(posedge clk);
        #1;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!got) begin
                    got        = 1'b1;
                    first_addr = mem_addr_o;
                    first_we   = mem_we_o;
                end
                last_addr = mem_addr_o;
                if (mem_we_o) begin
                    saw_wb = 1'b1;
                    wb_w1  = mem_wdata_o[63:32];
                end
            end
            if (!cpu_stall_o) begin
                done  = 1'b1;
                rdata = cpu_rdata_o;
            end else begin
                stalls++;
            end
        end
        txn_no++;
        $display("txn %0d %s addr=%08h wdata=%08h rdata=%08h stalls=%0d wb=%0d",
                 txn_no, we ? "ST" : "LD", addr, wdata, rdata, stalls, saw_wb);
        if (!done) begin
            chk("access_timeout", 0, 1);
            finish_run();
        end
    endtask

    int          st;
    bit          sw, fw;
    logic [31:0] fa, la, w1, rd;
    logic [255:0] pre;

    initial begin
        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        lat_fixed   = 3;
        pre = mem_line(2);
        pre[31:0] = 32'hDEAD_BEEF;
        mem_arr[2] = pre;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", cpu_stall_o, 0);
        chk("reset_mem_req", mem_req_o, 0);
        chk("reset_rdata", cpu_rdata_o, 0);
        @(posedge clk);
        #2 rst_i = 1'b1;

        // cold load
        access(0, 32'h40, 0, st, sw, fa, fw, la, w1, rd);
        chk("cold_addr", fa, 32'h40);
        chk("cold_we", fw, 0);
        chk("cold_rdata", rd, 32'hDEAD_BEEF);
        chk("cold_stalls", st, 6);

        // store hit then load hit
        access(1, 32'h44, 32'h1234_5678, st, sw, fa, fw, la, w1, rd);
        chk("store_hit_stalls", st, 0);
        access(0, 32'h44, 0, st, sw, fa, fw, la, w1, rd);
        chk("load_hit_stalls", st, 0);
        chk("load_hit_rdata", rd, 32'h1234_5678);

        // dirty eviction
        access(0, 32'h440, 0, st, sw, fa, fw, la, w1, rd);
        chk("dirty_saw_wb", sw, 1);
        chk("dirty_wb_addr", fa, 32'h40);
        chk("dirty_wb_we", fw, 1);
        chk("dirty_wb_word1", w1, 32'h1234_5678);
        chk("dirty_fetch_addr", la, 32'h440);
        chk("dirty_stalls", st, 11);

        // clean eviction back to the written-back line
        access(0, 32'h44, 0, st, sw, fa, fw, la, w1, rd);
        chk("clean_saw_wb", sw, 0);
        chk("clean_rdata", rd, 32'h1234_5678);
        chk("clean_stalls", st, 6);

        // spurious ack while idle
        @(posedge clk);
        #2;
        cpu_req_i   = 1'b0;
        mem_rdata_i = {8{32'hFFFF_FFFF}};
        mem_ack_i   = 1'b1;
        access(0, 32'h44, 0, st, sw, fa, fw, la, w1, rd);
        chk("spurious_stalls", st, 0);
        chk("spurious_rdata", rd, 32'h1234_5678);

        // reset during ALLOCATE
        lat_fixed = 20;
        @(posedge clk);
        #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h800;
        st = 0;
        while (!mem_req_o && st < 10) begin
            @(negedge clk);
            st++;
        end
        chk("abort_req_seen", mem_req_o, 1);
        @(posedge clk);
        #2;
        rst_i     = 1'b0;
        cpu_req_i = 1'b0;
        #1;
        chk("abort_mem_req", mem_req_o, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_i     = 1'b1;
        lat_fixed = 3;
        access(0, 32'h800, 0, st, sw, fa, fw, la, w1, rd);
        chk("abort_remiss_stalls", st, 6);
        chk("abort_remiss_addr", fa, 32'h800);
        access(0, 32'h44, 0, st, sw, fa, fw, la, w1, rd);
        chk("abort_reload_stalls", st, 6);
        chk("abort_reload_rdata", rd, 32'h1234_5678);

        // randomized phase
        lat_fixed = -1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                cpu_req_i  = 1'b0;
                cpu_addr_i = $urandom;
            end else begin
                access(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 5) |
                       ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
                       $urandom, st, sw, fa, fw, la, w1, rd);
            end
        end
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
        repeat (2) @(posedge clk);
        finish_run();
    end

    // Global time bound
    initial begin
        #800000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        finish_run();
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the CPU MEM stage and a multi-cycle line-wide data memory. It serves load/store hits combinationally in the MEM stage. On a miss it stalls the pipeline, writes back a dirty victim line, refills the line from memory, then completes the access. It replaces the zero-latency data memory port the MEM stage uses today.

## Interface
Parameters:
- LINES, 32: number of cache lines; power of two, ≥2.
- LINE_BITS, 256: line size, 8 × 32-bit words; fixed.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address (ALU result); bits [1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i & !cpu_we_i & !cpu_stall_o.
- cpu_stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- mem_req_o  out  1  memory request; held until mem_ack_i.
- mem_we_o  out  1  1 = line write-back, 0 = line fetch.
- mem_addr_o  out  32  line-aligned address; bits [4:0] = 0.
- mem_wdata_o  out  256  victim line data.
- mem_rdata_i  in  256  refill data; sampled when mem_ack_i = 1.
- mem_ack_i  in  1  single-cycle completion pulse.

## Operation
- Address split: word = addr[4:2]; index = addr[4+log2(LINES):5]; tag = the remaining upper bits (22 bits at LINES = 32).
- hit = valid[index] & (tag_arr[index] == tag).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE behaviour:
  - cpu_req_i = 0: no effect, stall = 0.
  - Load hit: cpu_rdata_o = selected word, combinational; stall = 0.
  - Store hit: word written at the edge; dirty set; stall = 0.
  - Miss: stall = 1 combinationally. Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
- WRITEBACK:
  - mem_req_o = 1, mem_we_o = 1.
  - mem_addr_o = {victim tag, index, 5'b0}; mem_wdata_o = victim line.
  - On mem_ack_i, go to ALLOCATE.
- ALLOCATE:
  - mem_req_o = 1, mem_we_o = 0.
  - mem_addr_o = {tag, index, 5'b0}.
  - On mem_ack_i, write mem_rdata_i into the line, set the tag, valid = 1, dirty = 0, and go to IDLE.
- After ALLOCATE, the access re-evaluates as a hit in IDLE. A store then merges its word and sets dirty.
- cpu_stall_o = 1 in WRITEBACK and ALLOCATE, and in IDLE on a miss.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_wdata_i stable while cpu_stall_o = 1. This is a guaranteed property of the frozen pipeline.
- A mem_ack_i arriving while mem_req_o = 0 is ignored.
- Reset:
  - state = IDLE; all valid and dirty bits = 0.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, cpu_stall_o = 0 (unless a miss is present after reset), cpu_rdata_o = 0 when no hit.
  - Tag and data arrays are not reset.
- Reset mid-miss aborts the operation: mem_req_o drops asynchronously and the dirty victim is discarded.

## Timing
- Hit latency is 0 cycles: same-cycle data, no stall.
- Clean miss: stall for 1 (IDLE detect) + N_fetch cycles (N_fetch = cycles until ack, inclusive), plus 1 cycle for the re-evaluation hit.
- Dirty miss adds N_wb cycles.
- mem_req_o rises the cycle after miss detection. It stays high through the ack cycle and changes or drops the following cycle.
- Back-to-back hits sustain one access per cycle.

## Structure
- Shared package dcache_pkg holds:
  - state encoding: IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2;
  - LINE_BITS, WORD_SEL_W = 3, OFFSET_W = 5;
  - field-width helper constants derived from LINES.
- One sub-module, dcache_array, holds the tag, valid, dirty and data storage. It has:
  - one combinational read port;
  - one synchronous write port supporting either a word write or a full-line write;
  - asynchronous clear of valid and dirty.
- The FSM, hit logic and muxing live in dcache_ctrl.

## Test plan
- **Cold load:** after reset, load 0x0000_0040. Expect stall; ALLOCATE request with mem_addr_o = 0x40, mem_we_o = 0; ack 4 cycles later with a line whose word 0 = 0xDEAD_BEEF. Then cpu_rdata_o = 0xDEAD_BEEF with stall = 0.
- **Hit sequence:** store 0x1234_5678 to 0x44, then load 0x44. Expect no stall on either, and the load returns 0x1234_5678.
- **Dirty eviction:** load 0x0000_0440 (same index as 0x40, different tag). Expect WRITEBACK to 0x40 first, with mem_wdata_o[63:32] = 0x1234_5678, then ALLOCATE from 0x440.
- **Clean eviction:** repeat an index conflict on an unmodified line. Expect no WRITEBACK; mem_we_o stays 0.
- **Reset during ALLOCATE:** assert rst_i low while mem_req_o = 1. Expect mem_req_o = 0 immediately; a subsequent load to the same address misses again.
- **Spurious ack:** pulse mem_ack_i while idle. Expect no state change or array update.
